// File: rtl/vc_evict_buffer_pkg.sv
// Shared L1.5 widths used by the victim-cache eviction buffer.
// Values mirror the L1.5 defines so the buffer lines up with the cache datapath.
package vc_evict_buffer_pkg;

  localparam int VC_ADDR_WIDTH       = 36;
  localparam int L15_CACHELINE_WIDTH = 128;
  localparam int VC_EVICT_BUF_DEPTH  = 4;

endpackage

// File: rtl/vc_evict_buffer.sv
// In-order eviction FIFO between L1.5 S3 and the victim cache store port.
// Also answers associative read probes against lines still waiting to be written.
module vc_evict_buffer
  import vc_evict_buffer_pkg::*;
#(
  parameter int DEPTH  = VC_EVICT_BUF_DEPTH,
  parameter int ADDR_W = VC_ADDR_WIDTH,
  parameter int DATA_W = L15_CACHELINE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    evict_val_i,
  input  logic [ADDR_W-1:0]       evict_addr_i,
  input  logic [DATA_W-1:0]       evict_data_i,
  output logic                    evict_rdy_o,
  output logic                    store_evict_val_o,
  output logic [ADDR_W-1:0]       store_evict_addr_o,
  output logic [DATA_W-1:0]       store_evict_data_o,
  input  logic                    store_evict_rdy_i,
  input  logic                    lookup_val_i,
  input  logic [ADDR_W-1:0]       lookup_addr_i,
  output logic                    lookup_hit_o,
  output logic [DATA_W-1:0]       lookup_data_o,
  output logic [$clog2(DEPTH):0]  occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              push;
  logic              pop;
  logic              probe_hit;
  logic [DATA_W-1:0] probe_data;
  logic [PTR_W-1:0]  idx;

  // Ready depends only on registered count, so the store-side ready never
  // reaches the upstream handshake combinationally.
  assign evict_rdy_o        = (count != FULL_COUNT);
  assign store_evict_val_o  = (count != '0);
  assign store_evict_addr_o = addr_mem[rd_ptr];
  assign store_evict_data_o = data_mem[rd_ptr];
  assign occupancy_o        = count;

  assign push = evict_val_i && evict_rdy_o;
  assign pop  = store_evict_val_o && store_evict_rdy_i;

  // Walk oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    probe_hit  = 1'b0;
    probe_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (valid[idx] && (addr_mem[idx] == lookup_addr_i)) begin
        probe_hit  = 1'b1;
        probe_data = data_mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      valid         <= '0;
      lookup_hit_o  <= 1'b0;
      lookup_data_o <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      lookup_hit_o  <= lookup_val_i && probe_hit;
      lookup_data_o <= (lookup_val_i && probe_hit) ? probe_data : '0;
    end
  end

  // Line storage is qualified by the valid bits, so it is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= evict_addr_i;
      data_mem[wr_ptr] <= evict_data_i;
    end
  end

endmodule

// File: tb/tb_vc_evict_buffer.sv
// Directed self-checking bench for vc_evict_buffer with hand-computed expectations.
module tb_vc_evict_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 36;
  localparam int DATA_W = 128;

  logic              clk;
  logic              rst_n;
  logic              evict_val_i;
  logic [ADDR_W-1:0] evict_addr_i;
  logic [DATA_W-1:0] evict_data_i;
  logic              evict_rdy_o;
  logic              store_evict_val_o;
  logic [ADDR_W-1:0] store_evict_addr_o;
  logic [DATA_W-1:0] store_evict_data_o;
  logic              store_evict_rdy_i;
  logic              lookup_val_i;
  logic [ADDR_W-1:0] lookup_addr_i;
  logic              lookup_hit_o;
  logic [DATA_W-1:0] lookup_data_o;
  logic [2:0]        occupancy_o;

  int checks_total;
  int checks_passed;

  vc_evict_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .evict_val_i        (evict_val_i),
    .evict_addr_i       (evict_addr_i),
    .evict_data_i       (evict_data_i),
    .evict_rdy_o        (evict_rdy_o),
    .store_evict_val_o  (store_evict_val_o),
    .store_evict_addr_o (store_evict_addr_o),
    .store_evict_data_o (store_evict_data_o),
    .store_evict_rdy_i  (store_evict_rdy_i),
    .lookup_val_i       (lookup_val_i),
    .lookup_addr_i      (lookup_addr_i),
    .lookup_hit_o       (lookup_hit_o),
    .lookup_data_o      (lookup_data_o),
    .occupancy_o        (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ev, input logic [ADDR_W-1:0] ea,
                               input logic [DATA_W-1:0] ed, input logic srdy,
                               input logic lv, input logic [ADDR_W-1:0] la);
    evict_val_i       = ev;
    evict_addr_i      = ea;
    evict_data_i      = ed;
    store_evict_rdy_i = srdy;
    lookup_val_i      = lv;
    lookup_addr_i     = la;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [ADDR_W-1:0] seq_addr(input int i);
    return 36'h2_0000_0000 + ADDR_W'(i * 64);
  endfunction

  function automatic logic [DATA_W-1:0] seq_data(input int i);
    return {32'hC0DE_0000 + 32'(i), 96'h0} | DATA_W'(i + 1);
  endfunction

  logic [ADDR_W-1:0] addr_x, addr_y, addr_p, addr_q;
  logic [DATA_W-1:0] data_a5, data_d1, data_d2, data_p, data_q;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    addr_x  = 36'h3_0000_1000;
    addr_y  = 36'h3_0000_2000;
    addr_p  = 36'h4_0000_0080;
    addr_q  = 36'h4_0000_00C0;
    data_a5 = {16{8'hA5}};
    data_d1 = {4{32'hD1D1_0001}};
    data_d2 = {4{32'hD2D2_0002}};
    data_p  = {4{32'h1234_5678}};
    data_q  = {4{32'h9ABC_DEF0}};

    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_evict_rdy", 128'(evict_rdy_o), 128'd1);
    checkOutput("rst_store_val", 128'(store_evict_val_o), 128'd0);
    checkOutput("rst_occupancy", 128'(occupancy_o), 128'd0);
    checkOutput("rst_hit", 128'(lookup_hit_o), 128'd0);
    checkOutput("rst_ldata", lookup_data_o, 128'd0);
    rst_n = 1'b1;

    // Single push then pop, no bypass while empty.
    applyStimulus(1'b1, 36'h1_0000_0040, data_a5, 1'b1, 1'b0, '0);
    checkOutput("single_no_bypass", 128'(store_evict_val_o), 128'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    checkOutput("single_val", 128'(store_evict_val_o), 128'd1);
    checkOutput("single_addr", 128'(store_evict_addr_o), 128'h1_0000_0040);
    checkOutput("single_data", store_evict_data_o, data_a5);
    checkOutput("single_occ1", 128'(occupancy_o), 128'd1);
    tick();
    checkOutput("single_occ0", 128'(occupancy_o), 128'd0);
    checkOutput("single_empty", 128'(store_evict_val_o), 128'd0);

    // Fill under backpressure, overflow push ignored, then drain in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, seq_addr(i), seq_data(i), 1'b0, 1'b0, '0);
      tick();
    end
    checkOutput("fill_rdy_low", 128'(evict_rdy_o), 128'd0);
    checkOutput("fill_occ4", 128'(occupancy_o), 128'd4);
    applyStimulus(1'b1, 36'hB_AD00_0000, {4{32'hBAD0_BAD0}}, 1'b0, 1'b0, '0);
    tick();
    checkOutput("overflow_occ", 128'(occupancy_o), 128'd4);
    checkOutput("stall_head_addr", 128'(store_evict_addr_o), 128'(seq_addr(0)));
    checkOutput("stall_head_data", store_evict_data_o, seq_data(0));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_val", 128'(store_evict_val_o), 128'd1);
      checkOutput("drain_addr", 128'(store_evict_addr_o), 128'(seq_addr(i)));
      checkOutput("drain_data", store_evict_data_o, seq_data(i));
      tick();
    end
    checkOutput("drain_occ0", 128'(occupancy_o), 128'd0);

    // Concurrent push/pop at count 2 across pointer wrap.
    for (int i = 10; i < 12; i++) begin
      applyStimulus(1'b1, seq_addr(i), seq_data(i), 1'b0, 1'b0, '0);
      tick();
    end
    for (int i = 12; i < 18; i++) begin
      applyStimulus(1'b1, seq_addr(i), seq_data(i), 1'b1, 1'b0, '0);
      checkOutput("pp_head", 128'(store_evict_addr_o), 128'(seq_addr(i - 2)));
      tick();
      checkOutput("pp_occ2", 128'(occupancy_o), 128'd2);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    for (int i = 16; i < 18; i++) begin
      checkOutput("pp_tail_data", store_evict_data_o, seq_data(i));
      tick();
    end
    checkOutput("pp_occ0", 128'(occupancy_o), 128'd0);

    // Youngest duplicate wins; absent address misses.
    applyStimulus(1'b1, addr_x, data_d1, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b1, addr_x, data_d2, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, addr_x);
    tick();
    checkOutput("young_hit", 128'(lookup_hit_o), 128'd1);
    checkOutput("young_data", lookup_data_o, data_d2);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, addr_y);
    tick();
    checkOutput("miss_hit", 128'(lookup_hit_o), 128'd0);
    checkOutput("miss_data", lookup_data_o, 128'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, addr_x);
    tick();
    checkOutput("idle_hit", 128'(lookup_hit_o), 128'd0);
    checkOutput("idle_data", lookup_data_o, 128'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    tick();
    tick();
    checkOutput("dup_drained", 128'(occupancy_o), 128'd0);

    // Probe in the pop cycle still hits; probe of a same-cycle push misses.
    applyStimulus(1'b1, addr_p, data_p, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, addr_p);
    tick();
    checkOutput("pop_probe_hit", 128'(lookup_hit_o), 128'd1);
    checkOutput("pop_probe_data", lookup_data_o, data_p);
    checkOutput("pop_probe_occ", 128'(occupancy_o), 128'd0);
    applyStimulus(1'b1, addr_q, data_q, 1'b0, 1'b1, addr_q);
    tick();
    checkOutput("push_probe_hit", 128'(lookup_hit_o), 128'd0);
    checkOutput("push_probe_data", lookup_data_o, 128'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, addr_q);
    tick();
    checkOutput("after_push_hit", 128'(lookup_hit_o), 128'd1);
    checkOutput("after_push_data", lookup_data_o, data_q);

    // Reset with three entries pending drops them.
    applyStimulus(1'b1, addr_x, data_d1, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b1, addr_y, data_d2, 1'b0, 1'b1, addr_q);
    tick();
    checkOutput("pre_rst_occ3", 128'(occupancy_o), 128'd3);
    checkOutput("pre_rst_hit", 128'(lookup_hit_o), 128'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, addr_q);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_occ", 128'(occupancy_o), 128'd0);
    checkOutput("midrst_val", 128'(store_evict_val_o), 128'd0);
    checkOutput("midrst_hit", 128'(lookup_hit_o), 128'd0);
    checkOutput("midrst_rdy", 128'(evict_rdy_o), 128'd1);
    tick();
    checkOutput("postrst_probe", 128'(lookup_hit_o), 128'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
